// File: rtl/trojan_vector_sequencer.sv
// rtl/trojan_vector_sequencer.sv - exhaustive stimulus sweep with response capture
//
// Applies every N_WIDTH-bit vector in ascending order. Each vector is held for
// HOLD_CYCLES cycles and then sampled for one cycle, when dut_out is captured.
// Optional feature macro: TROJAN_SIG_MISR_EN (serial CRC-16/0x1021 response
// signature seeded 0xFFFF; without it signature is tied to zero).
//
// Ports:
//   CK         clock, rising edge
//   reset      synchronous active-high reset
//   start      begin a sweep (ignored while busy)
//   abort      return to idle, keep partial results (wins over start)
//   dut_out    response bit, only observed while sampling
//   vec_out    stimulus vector, holds its last value when not valid
//   vec_valid  vec_out is being applied
//   sample     one-cycle capture strobe
//   resp_map   bit k = response captured for vector k
//   ones_count number of captured ones
//   signature  response signature
//   busy/done  sweep in progress / sweep complete

module trojan_vector_sequencer #(
    parameter int N_WIDTH     = 5,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       dut_out,
    output logic [N_WIDTH-1:0]         vec_out,
    output logic                       vec_valid,
    output logic                       sample,
    output logic [(2**N_WIDTH)-1:0]    resp_map,
    output logic [N_WIDTH:0]           ones_count,
    output logic [15:0]                signature,
    output logic                       busy,
    output logic                       done
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;

`ifdef TROJAN_SIG_MISR_EN
    logic [15:0] sig_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] s, input logic d);
        logic fb;
        fb = s[15] ^ d;
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

    always_ff @(posedge CK) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            vec_out    <= '0;
            vec_valid  <= 1'b0;
            sample     <= 1'b0;
            resp_map   <= '0;
            ones_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef TROJAN_SIG_MISR_EN
            sig_q      <= 16'h0000;
`endif
        end else if (abort) begin
            // Partial results and the last vector are kept for inspection.
            state     <= IDLE;
            hold_cnt  <= '0;
            vec_valid <= 1'b0;
            sample    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= APPLY;
                        hold_cnt   <= '0;
                        vec_out    <= '0;
                        vec_valid  <= 1'b1;
                        sample     <= 1'b0;
                        resp_map   <= '0;
                        ones_count <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef TROJAN_SIG_MISR_EN
                        sig_q      <= 16'hFFFF;
`endif
                    end
                end
                APPLY: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= SAMPLE;
                        sample   <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    resp_map[vec_out] <= dut_out;
                    ones_count        <= ones_count + (N_WIDTH + 1)'(dut_out);
`ifdef TROJAN_SIG_MISR_EN
                    sig_q             <= crc16_step(sig_q, dut_out);
`endif
                    sample <= 1'b0;
                    if (vec_out == '1) begin
                        // Last vector: no wrap, vec_out stays at all-ones.
                        state     <= DONE;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state   <= APPLY;
                        vec_out <= vec_out + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trojan_vector_sequencer.sv
// tb/tb_trojan_vector_sequencer.sv - directed scoreboard bench for trojan_vector_sequencer

module tb_trojan_vector_sequencer;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic dut_a = 1'b0;
    logic dut_b = 1'b1;

    logic [4:0]  vec_a, vec_b;
    logic        valid_a, valid_b, sample_a, sample_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] map_a, map_b;
    logic [5:0]  ones_a, ones_b;
    logic [15:0] sig_a, sig_b;

    trojan_vector_sequencer #(.N_WIDTH(5), .HOLD_CYCLES(1)) u_dut_a (
        .CK(CK), .reset(reset), .start(start), .abort(abort), .dut_out(dut_a),
        .vec_out(vec_a), .vec_valid(valid_a), .sample(sample_a), .resp_map(map_a),
        .ones_count(ones_a), .signature(sig_a), .busy(busy_a), .done(done_a)
    );

    trojan_vector_sequencer #(.N_WIDTH(5), .HOLD_CYCLES(3)) u_dut_b (
        .CK(CK), .reset(reset), .start(start), .abort(abort), .dut_out(dut_b),
        .vec_out(vec_b), .vec_valid(valid_b), .sample(sample_b), .resp_map(map_b),
        .ones_count(ones_b), .signature(sig_b), .busy(busy_b), .done(done_b)
    );

    logic        sel = 1'b0;
    logic [4:0]  m_vec;
    logic        m_valid, m_sample, m_busy, m_done;
    logic [31:0] m_map;
    logic [5:0]  m_ones;
    logic [15:0] m_sig;

    assign m_vec    = sel ? vec_b    : vec_a;
    assign m_valid  = sel ? valid_b  : valid_a;
    assign m_sample = sel ? sample_b : sample_a;
    assign m_busy   = sel ? busy_b   : busy_a;
    assign m_done   = sel ? done_b   : done_a;
    assign m_map    = sel ? map_b    : map_a;
    assign m_ones   = sel ? ones_b   : ones_a;
    assign m_sig    = sel ? sig_b    : sig_a;

    int checks = 0;
    int failures = 0;
    int mode = 0;          // 0: dut_a=0, 1: dut_a=vec_out[0]
    int cyc = 0;
    int hold_seen = 0;
    int exp_q[$];
    logic [31:0] mdl_map;
    logic [5:0]  mdl_ones;
    logic [15:0] mdl_sig;

    function automatic logic [15:0] crc_model(input logic [15:0] s, input logic d);
        logic [15:0] r;
        r = s << 1;
        if (s[15] != d) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mdl_map  = '0;
        mdl_ones = '0;
`ifdef TROJAN_SIG_MISR_EN
        mdl_sig  = 16'hFFFF;
`else
        mdl_sig  = 16'h0000;
`endif
    endtask

    // One clock: observe post-edge outputs, drive dut_out, score sample strobes.
    task automatic tick();
        int   v;
        logic d;
        @(posedge CK);
        #1;
        if (!sel) dut_a = (mode == 1) ? m_vec[0] : 1'b0;
        d = sel ? dut_b : dut_a;
        if (m_sample) begin
            if (exp_q.size() == 0) begin
                check("sample_unexpected", 64'(1), 64'(0));
            end else begin
                v = exp_q.pop_front();
                check("vec_order", 64'(m_vec), 64'(v));
                check("hold_len", 64'(hold_seen), 64'(sel ? 3 : 1));
                mdl_map[v] = d;
                mdl_ones   = mdl_ones + 6'(d);
`ifdef TROJAN_SIG_MISR_EN
                mdl_sig    = crc_model(mdl_sig, d);
`endif
            end
            hold_seen = 0;
        end else if (m_valid) begin
            hold_seen++;
        end
    endtask

    task automatic begin_sweep();
        exp_q.delete();
        for (int v = 0; v < 32; v++) exp_q.push_back(v);
        model_clear();
        hold_seen = 0;
        start = 1'b1;
        cyc = 0;
        tick();
        cyc = 1;
        start = 1'b0;
        check("start_vec0",   64'(m_vec),   64'(0));
        check("start_valid",  64'(m_valid), 64'(1));
        check("start_busy",   64'(m_busy),  64'(1));
        check("start_done",   64'(m_done),  64'(0));
        check("start_map",    64'(m_map),   64'(0));
        check("start_ones",   64'(m_ones),  64'(0));
    endtask

    task automatic finish_sweep(input int hold, input logic [31:0] map_exp, input int ones_exp);
        int budget;
        budget = 32 * (hold + 1) + 20;
        while (!m_done && cyc < budget) begin
            tick();
            cyc++;
        end
        check("done_cycle", 64'(cyc), 64'(32 * (hold + 1) + 1));
        check("done_map",   64'(m_map),  64'(map_exp));
        check("model_map",  64'(m_map),  64'(mdl_map));
        check("done_ones",  64'(m_ones), 64'(ones_exp));
        check("done_sig",   64'(m_sig),  64'(mdl_sig));
        check("done_busy",  64'(m_busy), 64'(0));
        check("done_valid", 64'(m_valid), 64'(0));
        check("all_vectors", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
        check("done_hold",  64'(m_done), 64'(1));
    endtask

    task automatic advance_to(input int v);
        int n;
        n = 0;
        while (!(m_valid && !m_sample && m_vec == 5'(v)) && n < 300) begin
            tick();
            n++;
        end
        check("advance_reached", 64'(n < 300), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},    64'(m_vec),    64'(0));
        check({tag, "_valid"},  64'(m_valid),  64'(0));
        check({tag, "_sample"}, 64'(m_sample), 64'(0));
        check({tag, "_map"},    64'(m_map),    64'(0));
        check({tag, "_ones"},   64'(m_ones),   64'(0));
        check({tag, "_sig"},    64'(m_sig),    64'(0));
        check({tag, "_busy"},   64'(m_busy),   64'(0));
        check({tag, "_done"},   64'(m_done),   64'(0));
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // All-zero response sweep
        mode = 0;
        begin_sweep();
        finish_sweep(1, 32'h0000_0000, 0);

        // Response = vec_out[0], started from DONE
        mode = 1;
        begin_sweep();
        finish_sweep(1, 32'hAAAA_AAAA, 16);

        // HOLD_CYCLES=3 instance with constant-one response
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sel = 1'b1;
        begin_sweep();
        finish_sweep(3, 32'hFFFF_FFFF, 32);
        sel = 1'b0;

        // Abort during vector 10
        mode = 1;
        begin_sweep();
        advance_to(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",  64'(m_busy),  64'(0));
        check("abort_done",  64'(m_done),  64'(0));
        check("abort_valid", 64'(m_valid), 64'(0));
        check("abort_vec",   64'(m_vec),   64'(10));
        check("abort_low",   64'(m_map[9:0]), 64'(10'h2AA));
        check("abort_map",   64'(m_map),   64'(mdl_map));
        check("abort_ones",  64'(m_ones),  64'(5));
        check("abort_sig",   64'(m_sig),   64'(mdl_sig));
        tick();
        check("abort_idle",  64'(m_busy),  64'(0));
        begin_sweep();
        finish_sweep(1, 32'hAAAA_AAAA, 16);

        // Start ignored while busy, then start+abort together
        begin_sweep();
        advance_to(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_vec",    64'(m_vec),    64'(5));
        check("busy_start_sample", 64'(m_sample), 64'(1));
        check("busy_start_busy",   64'(m_busy),   64'(1));
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("both_busy",  64'(m_busy),  64'(0));
        check("both_done",  64'(m_done),  64'(0));
        check("both_valid", 64'(m_valid), 64'(0));
        check("both_vec",   64'(m_vec),   64'(5));
        tick();
        check("both_idle",  64'(m_busy),  64'(0));

        // Reset at vector 20
        begin_sweep();
        advance_to(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        begin_sweep();
        finish_sweep(1, 32'hAAAA_AAAA, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trojan_vector_sequencer.md
TROJAN_VECTOR_SEQUENCER -- requirements
Module: trojan_vector_sequencer

Interface
REQ-001 SHALL have parameter N_WIDTH, default 5: stimulus vector width; the block applies 2^N_WIDTH vectors.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1, minimum 1: cycles each vector is held before sampling.
REQ-003 SHALL have port CK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begins a sweep.
REQ-006 SHALL have port abort, input, 1: terminates a sweep.
REQ-007 SHALL have port dut_out, input, 1: single-bit response from the device under test.
REQ-008 SHALL have port vec_out, output, N_WIDTH: stimulus to the DUT; MSB is bit N_WIDTH-1.
REQ-009 SHALL have port vec_valid, output, 1: vec_out is being applied.
REQ-010 SHALL have port sample, output, 1: one-cycle strobe marking the cycle dut_out is captured.
REQ-011 SHALL have port resp_map, output, 2^N_WIDTH: bit k holds the response captured for vector k.
REQ-012 SHALL have port ones_count, output, N_WIDTH+1: number of captured responses equal to 1.
REQ-013 SHALL have port signature, output, 16: response signature.
REQ-014 SHALL have ports busy and done, output, 1 each: sweep in progress; sweep complete.

Function
REQ-015 SHALL implement the FSM states IDLE, APPLY, SAMPLE and DONE.
REQ-016 IDLE or DONE with start=1 and abort=0 SHALL go to APPLY next cycle with vec_out=0 and resp_map, ones_count and signature cleared.
REQ-017 APPLY SHALL last exactly HOLD_CYCLES cycles, with vec_valid=1 and vec_out stable, then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle with sample=1 and vec_valid=1, capturing dut_out into resp_map[vec_out] and adding dut_out to ones_count.
REQ-019 From SAMPLE, if vec_out is not 2^N_WIDTH-1 the block SHALL increment vec_out and go to APPLY; otherwise it SHALL go to DONE.
REQ-020 Vectors SHALL be applied in ascending binary order 0 to 2^N_WIDTH-1 with no wrap and no repeats.
REQ-021 Each vector SHALL take HOLD_CYCLES+1 cycles; if start is sampled at cycle 0, done SHALL rise at cycle 2^N_WIDTH*(HOLD_CYCLES+1)+1 (65 at the defaults).
REQ-022 busy SHALL be 1 in APPLY and SAMPLE only; done SHALL be 1 in DONE only and SHALL hold until the next start, abort or reset.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 abort=1 in any state SHALL go to IDLE next cycle; partial resp_map, ones_count and signature SHALL be retained and done SHALL be 0.
REQ-025 When start and abort are both 1 in the same cycle, abort SHALL win.
REQ-026 dut_out SHALL be ignored outside SAMPLE.
REQ-027 vec_out SHALL hold its last value when vec_valid=0.

Reset
REQ-028 reset=1 SHALL force IDLE and the following values on the next edge: vec_out=0, vec_valid=0, sample=0, resp_map=0, ones_count=0, signature=0, busy=0, done=0.
REQ-029 reset SHALL take priority over start and abort, and reset in mid-sweep SHALL discard all results.

Configuration
REQ-030 The macro TROJAN_SIG_MISR_EN SHALL control the signature feature.
REQ-031 With TROJAN_SIG_MISR_EN defined:
- signature SHALL be seeded to 0xFFFF on start.
- Each SAMPLE SHALL update it as a serial CRC-16 with polynomial 0x1021: fb = signature[15] XOR dut_out; signature = (signature<<1) XOR (fb ? 0x1021 : 0).
REQ-032 With TROJAN_SIG_MISR_EN undefined, signature SHALL be constant 0 and no MISR logic SHALL be present.

Verification
REQ-033 The bench SHALL drive dut_out=0 with a start pulse and check: done at cycle 65; resp_map=0x00000000; ones_count=0; vec_out observed 0..31 in order.
REQ-034 The bench SHALL drive dut_out=vec_out[0] and check: resp_map=0xAAAAAAAA; ones_count=16; with the macro defined, signature equals a bit-serial CRC-16/0x1021 model seeded 0xFFFF.
REQ-035 The bench SHALL set HOLD_CYCLES=3 with dut_out=1 and check: each vector held 3 cycles before sample; done at cycle 129; resp_map=0xFFFFFFFF; ones_count=32.
REQ-036 The bench SHALL assert abort during vector 10 and check: IDLE next cycle; done=0; resp_map bits 0..9 retained; a later start restarts at vector 0 with results cleared.
REQ-037 The bench SHALL pulse start at vector 5, then assert start and abort together, and check: the start pulse is ignored; the combined cycle aborts to IDLE.
REQ-038 The bench SHALL assert reset at vector 20 and check: all outputs 0 on the next edge; a following start yields a complete, correct sweep.
